batch_loader: RTL

BATCH_LOADER -- requirements
Module: batch_loader

---
 rtl/batch_loader.sv | 106 ++++++++++
 1 files changed

// File: rtl/batch_loader.sv
// batch_loader: pulls one training batch (M samples of N float features, then M
// integer labels) from a FWFT FIFO and writes it into the X/Y buffers, expanding
// each label into a K-wide one-hot row of IEEE-754 floats.
//
// Ports:
//   clk, rst (async, active-low)
//   readData/readEmpty/readEn  FWFT FIFO head, empty flag, combinational pop
//   buf_we/buf_sel/buf_addr/buf_data  registered buffer write (sel 0 = X, 1 = Y)
//   output_z_stb/output_z_ack  batch-ready handshake with the trainer
//   batch_cnt                  acknowledged batches, wraps at 2047
//   label_err                  sticky out-of-range label flag
//
// Build option: LOADER_LABEL_CHECK_EN enables label_err; without it label_err is 0.
// Out-of-range labels always produce an all-zero Y row.
module batch_loader #(
  parameter int M  = 100,
  parameter int N  = 784,
  parameter int K  = 10,
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   readData,
  input  logic          readEmpty,
  output logic          readEn,
  output logic          buf_we,
  output logic          buf_sel,
  output logic [AW-1:0] buf_addr,
  output logic [31:0]   buf_data,
  output logic          output_z_stb,
  input  logic          output_z_ack,
  output logic [10:0]   batch_cnt,
  output logic          label_err
);
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  typedef enum logic [1:0] {LOAD_X, LOAD_Y, EXPAND, DONE} state_t;
  state_t r_state, w_next;
  logic [AW-1:0] r_xaddr, r_yaddr;
  logic [MW-1:0] r_i;
  logic [KW-1:0] r_k;
  logic [31:0]   r_label;
  logic          w_wr, w_x_last, w_k_last, w_i_last;
  // r_xaddr walks i*N+j and r_yaddr walks i*K+k sequentially, so no multipliers
  assign w_x_last = r_xaddr == AW'(M * N - 1);
  assign w_k_last = r_k == KW'(K - 1);
  assign w_i_last = r_i == MW'(M - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= LOAD_X;
    else      r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LOAD_X:  if (readEn && w_x_last) w_next = LOAD_Y;
      LOAD_Y:  if (readEn) w_next = EXPAND;
      EXPAND:  if (w_k_last) w_next = w_i_last ? DONE : LOAD_Y;
      DONE:    if (output_z_ack) w_next = LOAD_X;
      default: w_next = LOAD_X;
    endcase
  end
  always_comb begin
    readEn       = rst && !readEmpty && (r_state == LOAD_X || r_state == LOAD_Y);
    output_z_stb = r_state == DONE;
    w_wr         = (readEn && r_state == LOAD_X) || r_state == EXPAND;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_we    <= 1'b0;
      buf_sel   <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      batch_cnt <= '0;
      r_xaddr   <= '0;
      r_yaddr   <= '0;
      r_i       <= '0;
      r_k       <= '0;
      r_label   <= '0;
    end else begin
      buf_we <= w_wr;
      if (w_wr) begin
        buf_sel  <= r_state == EXPAND;
        buf_addr <= (r_state == EXPAND) ? r_yaddr : r_xaddr;
        // a label >= K never matches any k, giving an all-zero row
        buf_data <= (r_state != EXPAND) ? readData :
                    (r_label == 32'(r_k)) ? 32'h3F80_0000 : 32'h0;
      end
      if (readEn && r_state == LOAD_X) r_xaddr <= w_x_last ? '0 : r_xaddr + AW'(1);
      if (readEn && r_state == LOAD_Y) r_label <= readData;
      if (r_state == EXPAND) begin
        r_k     <= w_k_last ? '0 : r_k + KW'(1);
        r_yaddr <= (w_k_last && w_i_last) ? '0 : r_yaddr + AW'(1);
        if (w_k_last) r_i <= w_i_last ? '0 : r_i + MW'(1);
      end
      if (output_z_stb && output_z_ack) batch_cnt <= batch_cnt + 11'd1;
    end
  end
`ifdef LOADER_LABEL_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                 label_err <= 1'b0;
    else if (readEn && r_state == LOAD_Y && readData >= 32'(K)) label_err <= 1'b1;
  end
`else
  assign label_err = 1'b0;
`endif
endmodule
